out_stream_drain: RTL and testbench

- Sink-side buffer for the accelerator's valid-only result stream (out_sample/out_valid). That stream has no backpressure.
- Absorbs results into a first-word-fall-through FIFO and re-emits them on a ready/valid master interface for the host/DMA side.
- Tags frame boundaries with m_last.
- Reports overflow, where input arrives while the FIFO is full and cannot be held.

---
 rtl/stream_pkg.sv | 19 +
 rtl/sfifo_core.sv | 53 +++++
 rtl/out_stream_drain.sv | 94 +++++++++
 tb/tb_out_stream_drain.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and sizing helpers for the output stream drain.
package stream_pkg;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 16;
  localparam int DEF_PTR_W      = $clog2(DEF_DEPTH) + 1;

  typedef logic signed [DEF_DATA_WIDTH-1:0] sample_t;

  // One FIFO slot: the sample plus its end-of-frame tag.
  typedef struct packed {
    logic    last;
    sample_t sample;
  } entry_t;

  // Pointer width carries one extra wrap bit so full/empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sfifo_core.sv
// First-word-fall-through FIFO core: storage, wrap-bit pointers, flags, level.
module sfifo_core
  import stream_pkg::*;
#(
  parameter int W     = DEF_DATA_WIDTH + 1,
  parameter int DEPTH = DEF_DEPTH,
  parameter int PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] level
);
  localparam int AW = PW - 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  // Pointers advance on their own strobe; depth is a power of two so they wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // Pointer registers; reset flushes every stored entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents need no reset because empty masks the head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign level = wr_ptr_q - rd_ptr_q;
endmodule

// File: rtl/out_stream_drain.sv
// Buffers a valid-only result stream into a FIFO, re-emits it ready/valid,
// tags frame ends with m_last and accounts for samples dropped on overflow.
module out_stream_drain
  import stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int FRAME_LEN  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DATA_WIDTH-1:0] in_sample,
  input  logic                         in_valid,
  output logic signed [DATA_WIDTH-1:0] m_data,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic                         m_last,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         drop_count,
  input  logic                         clr_status
);
  localparam int PW    = ptr_w(DEPTH);
  localparam int POS_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef logic signed [DATA_WIDTH-1:0] smp_t;
  typedef struct packed {
    logic last;
    smp_t sample;
  } ent_t;

  ent_t wr_ent, rd_ent;
  logic full, empty, push, pop, drop;

  logic [POS_W-1:0]     pos_q, pos_d;
  logic                 overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop  = m_valid & m_ready;
  assign push = in_valid & (~full | pop);
  assign drop = in_valid & full & ~pop;

  assign wr_ent.last   = (pos_q == POS_W'(FRAME_LEN - 1));
  assign wr_ent.sample = in_sample;

  sfifo_core #(.W($bits(ent_t)), .DEPTH(DEPTH), .PW(PW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_ent),
    .rdata (rd_ent),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign m_valid    = ~empty;
  assign m_data     = empty ? '0 : rd_ent.sample;
  assign m_last     = ~empty & rd_ent.last;
  assign overflow   = overflow_q;
  assign drop_count = drop_cnt_q;

  // Frame position follows every input beat, kept or dropped; status clears before counting.
  always_comb begin
    pos_d      = pos_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (in_valid)
      pos_d = wr_ent.last ? '0 : pos_q + POS_W'(1);
    if (clr_status) begin
      overflow_d = drop;
      drop_cnt_d = drop ? CNT_WIDTH'(1) : '0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
    end
  end

  // Framing and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q      <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      pos_q      <= pos_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
endmodule

// File: tb/tb_out_stream_drain.sv
// Directed bench for out_stream_drain (DEPTH=4, FRAME_LEN=4, CNT_WIDTH=2).
module tb_out_stream_drain;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic signed [DW-1:0] in_sample = '0;
  logic                 in_valid = 1'b0;
  logic signed [DW-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic                 m_last;
  logic [2:0]           level;
  logic                 overflow;
  logic [1:0]           drop_count;
  logic                 clr_status = 1'b0;

  int pass_cnt = 0;
  int total    = 0;

  out_stream_drain #(.DATA_WIDTH(DW), .DEPTH(4), .FRAME_LEN(4), .CNT_WIDTH(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_sample  (in_sample),
    .in_valid   (in_valid),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count),
    .clr_status (clr_status)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; m_ready = 1'b0; clr_status = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic fill(input int first, input int n);
    m_ready = 1'b0;
    for (int i = 0; i < n; i++) begin
      in_sample = DW'(first + i); in_valid = 1'b1;
      cyc();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0]; in_sample = DW'(100 + i);
      @(negedge clk);
    end
    #6;
    rst = 1'b0; in_valid = 1'b0;
    total++; if (m_valid !== 1'b0) $display("FAIL rst_m_valid got %0b exp 0", m_valid); else pass_cnt++;
    total++; if (m_last !== 1'b0) $display("FAIL rst_m_last got %0b exp 0", m_last); else pass_cnt++;
    total++; if (m_data !== 16'sd0) $display("FAIL rst_m_data got %0d exp 0", m_data); else pass_cnt++;
    total++; if (level !== 3'd0) $display("FAIL rst_level got %0d exp 0", level); else pass_cnt++;
    total++; if (overflow !== 1'b0) $display("FAIL rst_overflow got %0b exp 0", overflow); else pass_cnt++;
    total++; if (drop_count !== 2'd0) $display("FAIL rst_drop_count got %0d exp 0", drop_count); else pass_cnt++;
  endtask

  // Reset leaves frame position 0, so the fourth input carries m_last.
  task automatic test_streaming();
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_sample = DW'(i); in_valid = 1'b1;
      cyc();
      total++; if (m_valid !== 1'b1 || m_data !== DW'(i))
        $display("FAIL stream_data[%0d] got v=%0b d=%0d exp v=1 d=%0d", i, m_valid, m_data, i); else pass_cnt++;
      total++; if (m_last !== (i == 4))
        $display("FAIL stream_last[%0d] got %0b exp %0b", i, m_last, (i == 4)); else pass_cnt++;
      total++; if (level !== 3'd1) $display("FAIL stream_level[%0d] got %0d exp 1", i, level); else pass_cnt++;
    end
    in_valid = 1'b0;
    cyc();
    total++; if (m_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL stream_drained got v=%0b lvl=%0d exp v=0 lvl=0", m_valid, level); else pass_cnt++;
    total++; if (drop_count !== 2'd0) $display("FAIL stream_drops got %0d exp 0", drop_count); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int exp_d [4] = '{10, 11, 12, 13};
    do_reset();
    fill(10, 4);
    total++; if (level !== 3'd4 || overflow !== 1'b0)
      $display("FAIL ovf_full got lvl=%0d ovf=%0b exp lvl=4 ovf=0", level, overflow); else pass_cnt++;
    in_sample = 16'sd14; in_valid = 1'b1;
    cyc();
    total++; if (overflow !== 1'b1 || drop_count !== 2'd1)
      $display("FAIL ovf_first_drop got ovf=%0b cnt=%0d exp ovf=1 cnt=1", overflow, drop_count); else pass_cnt++;
    in_sample = 16'sd15;
    cyc();
    in_valid = 1'b0;
    total++; if (level !== 3'd4 || drop_count !== 2'd2)
      $display("FAIL ovf_after got lvl=%0d cnt=%0d exp lvl=4 cnt=2", level, drop_count); else pass_cnt++;
    total++; if (m_data !== 16'sd10) $display("FAIL ovf_stall_head got %0d exp 10", m_data); else pass_cnt++;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (m_valid !== 1'b1 || m_data !== DW'(exp_d[i]) || m_last !== (i == 3))
        $display("FAIL ovf_drain[%0d] got v=%0b d=%0d l=%0b exp v=1 d=%0d l=%0b",
                 i, m_valid, m_data, m_last, exp_d[i], (i == 3)); else pass_cnt++;
      cyc();
    end
    total++; if (m_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL ovf_empty got v=%0b lvl=%0d exp v=0 lvl=0", m_valid, level); else pass_cnt++;
    cyc();
    total++; if (m_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL empty_ready got v=%0b lvl=%0d exp v=0 lvl=0", m_valid, level); else pass_cnt++;
  endtask

  task automatic test_full_push_pop();
    int exp_d [4] = '{11, 12, 13, 20};
    do_reset();
    fill(10, 4);
    in_sample = 16'sd20; in_valid = 1'b1; m_ready = 1'b1;
    cyc();
    in_valid = 1'b0; m_ready = 1'b0;
    total++; if (level !== 3'd4 || drop_count !== 2'd0 || overflow !== 1'b0)
      $display("FAIL fpp_state got lvl=%0d cnt=%0d ovf=%0b exp lvl=4 cnt=0 ovf=0", level, drop_count, overflow); else pass_cnt++;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (m_data !== DW'(exp_d[i]) || m_last !== (i == 2))
        $display("FAIL fpp_drain[%0d] got d=%0d l=%0b exp d=%0d l=%0b", i, m_data, m_last, exp_d[i], (i == 2)); else pass_cnt++;
      cyc();
    end
    m_ready = 1'b0;
  endtask

  task automatic test_status_clear();
    do_reset();
    fill(1, 4);
    in_valid = 1'b1; in_sample = 16'sd5;
    cyc();
    in_valid = 1'b0; clr_status = 1'b1;
    cyc();
    total++; if (overflow !== 1'b0 || drop_count !== 2'd0)
      $display("FAIL clr_alone got ovf=%0b cnt=%0d exp ovf=0 cnt=0", overflow, drop_count); else pass_cnt++;
    in_valid = 1'b1;
    cyc();
    clr_status = 1'b0;
    total++; if (overflow !== 1'b1 || drop_count !== 2'd1)
      $display("FAIL clr_with_drop got ovf=%0b cnt=%0d exp ovf=1 cnt=1", overflow, drop_count); else pass_cnt++;
    for (int i = 0; i < 4; i++) cyc();
    in_valid = 1'b0;
    total++; if (overflow !== 1'b1 || drop_count !== 2'd3)
      $display("FAIL cnt_saturate got ovf=%0b cnt=%0d exp ovf=1 cnt=3", overflow, drop_count); else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    fill(7, 3);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    total++; if (m_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL midrst got v=%0b lvl=%0d exp v=0 lvl=0", m_valid, level); else pass_cnt++;
    fill(40, 4);
    total++; if (level !== 3'd4) $display("FAIL midrst_level got %0d exp 4", level); else pass_cnt++;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (m_data !== DW'(40 + i) || m_last !== (i == 3))
        $display("FAIL midrst_drain[%0d] got d=%0d l=%0b exp d=%0d l=%0b", i, m_data, m_last, 40 + i, (i == 3)); else pass_cnt++;
      cyc();
    end
    m_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_overflow();
    test_full_push_pop();
    test_status_clear();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
